// File: rtl/ram_arb2_ctrl.sv
// Two-requester arbiter and sequencer for a simple dual-port RAM. It uses burst-limited
// round-robin granting, drives the RAM ports, and returns read data with a per-requester valid.
//
// owner_q | meaning
// --------+------------------------------------------------------------------
// A (0)   | A holds the burst; it keeps winning ties until burst_q hits the limit
// B (1)   | B holds the burst; it keeps winning ties until burst_q hits the limit
module ram_arb2_ctrl #(
   parameter int CAddrLen  = 8,
   parameter int CDataLen  = 16,
   parameter int CBurstMax = 4
) (
   input  logic                AClkH,
   input  logic                AResetB,
   input  logic                AClkHEn,
   input  logic                AReqA,
   input  logic                AReqB,
   input  logic                AWrA,
   input  logic                AWrB,
   input  logic [CAddrLen-1:0] AAddrA,
   input  logic [CAddrLen-1:0] AAddrB,
   input  logic [CDataLen-1:0] AMosiA,
   input  logic [CDataLen-1:0] AMosiB,
   output logic                ARdyA,
   output logic                ARdyB,
   output logic                ARspValA,
   output logic                ARspValB,
   output logic [CDataLen-1:0] ARspData,
   output logic [CAddrLen-1:0] ARamAddrWr,
   output logic [CAddrLen-1:0] ARamAddrRd,
   output logic [CDataLen-1:0] ARamMosi,
   output logic                ARamWrEn,
   input  logic [CDataLen-1:0] ARamMiso
);

   localparam logic [3:0] BurstMax = 4'(CBurstMax);
   localparam logic       OwnA     = 1'b0;
   localparam logic       OwnB     = 1'b1;

   logic       owner_q, owner_d;
   logic [3:0] burst_q, burst_d;
   logic       rsp_a_q, rsp_a_d;
   logic       rsp_b_q, rsp_b_d;

   logic burst_full;
   logic pick_a, pick_b;
   logic grant_a, grant_b, grant_any;
   logic grant_who;

   // Tie-break: the owner keeps the port until its burst is exhausted, then the other side wins.
   assign burst_full = (burst_q >= BurstMax);
   assign pick_a     = AReqA & (~AReqB
                              | ((owner_q == OwnA) & ~burst_full)
                              | ((owner_q == OwnB) &  burst_full));
   assign pick_b     = AReqB & ~pick_a;
   assign grant_a    = AClkHEn & pick_a;
   assign grant_b    = AClkHEn & pick_b;
   assign grant_any  = grant_a | grant_b;
   assign grant_who  = grant_b ? OwnB : OwnA;

   always_ff @(posedge AClkH or negedge AResetB) begin
      if (!AResetB) begin
         owner_q <= OwnA;
         burst_q <= '0;
         rsp_a_q <= 1'b0;
         rsp_b_q <= 1'b0;
      end else if (AClkHEn) begin
         owner_q <= owner_d;
         burst_q <= burst_d;
         rsp_a_q <= rsp_a_d;
         rsp_b_q <= rsp_b_d;
      end
   end

   always_comb begin
      owner_d = owner_q;
      burst_d = '0;
      rsp_a_d = grant_a & ~AWrA;
      rsp_b_d = grant_b & ~AWrB;
      if (grant_any) begin
         if (grant_who == owner_q) begin
            burst_d = burst_full ? BurstMax : 4'(burst_q + 4'd1);
         end else begin
            owner_d = grant_who;
            burst_d = 4'd1;
         end
      end
   end

   always_comb begin
      ARdyA      = grant_a;
      ARdyB      = grant_b;
      ARamAddrWr = AAddrA;
      ARamAddrRd = AAddrA;
      ARamMosi   = AMosiA;
      ARamWrEn   = (grant_a & AWrA) | (grant_b & AWrB);
      if (grant_b) begin
         ARamAddrWr = AAddrB;
         ARamAddrRd = AAddrB;
         ARamMosi   = AMosiB;
      end
      ARspValA   = rsp_a_q;
      ARspValB   = rsp_b_q;
      // The RAM holds its read address while the enable is low, so passthrough data stays valid.
      ARspData   = ARamMiso;
   end

endmodule

// File: tb/tb_ram_arb2_ctrl.sv
// Directed bench for ram_arb2_ctrl with a behavioural dual-port RAM attached.
module tb_ram_arb2_ctrl;
   localparam int AW = 8;
   localparam int DW = 16;

   logic          AClkH = 1'b0;
   logic          AResetB, AClkHEn;
   logic          AReqA, AReqB, AWrA, AWrB;
   logic [AW-1:0] AAddrA, AAddrB;
   logic [DW-1:0] AMosiA, AMosiB;
   logic          ARdyA, ARdyB, ARspValA, ARspValB, ARamWrEn;
   logic [DW-1:0] ARspData, ARamMosi, ARamMiso;
   logic [AW-1:0] ARamAddrWr, ARamAddrRd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 AClkH = ~AClkH;

   ram_arb2_ctrl #(.CAddrLen(AW), .CDataLen(DW), .CBurstMax(4)) dut (
      .AClkH(AClkH), .AResetB(AResetB), .AClkHEn(AClkHEn),
      .AReqA(AReqA), .AReqB(AReqB), .AWrA(AWrA), .AWrB(AWrB),
      .AAddrA(AAddrA), .AAddrB(AAddrB), .AMosiA(AMosiA), .AMosiB(AMosiB),
      .ARdyA(ARdyA), .ARdyB(ARdyB), .ARspValA(ARspValA), .ARspValB(ARspValB),
      .ARspData(ARspData), .ARamAddrWr(ARamAddrWr), .ARamAddrRd(ARamAddrRd),
      .ARamMosi(ARamMosi), .ARamWrEn(ARamWrEn), .ARamMiso(ARamMiso)
   );

   // RAM: registered addresses, write commits one edge after capture, combinational read.
   logic [DW-1:0] mem [256];
   logic [AW-1:0] ram_wa_q, ram_ra_q;
   logic [DW-1:0] ram_wd_q;
   logic          ram_we_q;

   always @(posedge AClkH or negedge AResetB) begin
      if (!AResetB) begin
         ram_wa_q <= '0;
         ram_ra_q <= '0;
         ram_wd_q <= '0;
         ram_we_q <= 1'b0;
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (AClkHEn) begin
         ram_wa_q <= ARamAddrWr;
         ram_wd_q <= ARamMosi;
         ram_we_q <= ARamWrEn;
         ram_ra_q <= ARamAddrRd;
         if (ram_we_q) mem[ram_wa_q] <= ram_wd_q;
      end
   end
   assign ARamMiso = mem[ram_ra_q];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
      AReqA = ra; AWrA = wa; AAddrA = aa; AMosiA = da;
      AReqB = rb; AWrB = wb; AAddrB = ab; AMosiB = db;
   endtask

   task automatic idle();
      drive(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
   endtask

   task automatic cyc();
      @(posedge AClkH);
      #1;
   endtask

   bit exp_a [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};

   initial begin
      AResetB = 1'b0;
      AClkHEn = 1'b1;
      idle();
      #12;
      check("rst_rspA", ARspValA, 0);
      check("rst_rspB", ARspValB, 0);
      check("rst_rdyA", ARdyA, 0);
      check("rst_wren", ARamWrEn, 0);
      AResetB = 1'b1;
      cyc();

      // A write then read-after-write at 0x10
      drive(1, 1, 8'h10, 16'h1234, 0, 0, 8'h00, 16'h0000);
      #2;
      check("t1_wr_rdyA", ARdyA, 1);
      check("t1_wr_wren", ARamWrEn, 1);
      check("t1_wr_addr", ARamAddrWr, 8'h10);
      check("t1_wr_mosi", ARamMosi, 16'h1234);
      cyc();
      drive(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
      #2;
      check("t1_rd_rdyA", ARdyA, 1);
      check("t1_rd_wren", ARamWrEn, 0);
      check("t1_wr_norsp", ARspValA, 0);
      cyc();
      idle();
      #2;
      check("t1_rspA", ARspValA, 1);
      check("t1_data", ARspData, 16'h1234);
      check("t1_rspB", ARspValB, 0);
      cyc();
      #2;
      check("t1_rspA_off", ARspValA, 0);

      // preload: B @0x20, A @0x30, then an idle cycle leaves owner A with an empty burst
      drive(0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'h5678);
      #2;
      check("pre_rdyB", ARdyB, 1);
      check("pre_addrB", ARamAddrWr, 8'h20);
      cyc();
      drive(1, 1, 8'h30, 16'h9ABC, 0, 0, 8'h00, 16'h0000);
      #2;
      check("pre_rdyA", ARdyA, 1);
      cyc();
      idle();
      cyc();

      // both requesters read continuously
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
         #2;
         check($sformatf("t2_rdyA_%0d", i), ARdyA, exp_a[i]);
         check($sformatf("t2_rdyB_%0d", i), ARdyB, !exp_a[i]);
         check($sformatf("t2_raddr_%0d", i), ARamAddrRd, exp_a[i] ? 8'h10 : 8'h20);
         if (i > 0) begin
            check($sformatf("t2_rspA_%0d", i), ARspValA, exp_a[i-1]);
            check($sformatf("t2_rspB_%0d", i), ARspValB, !exp_a[i-1]);
            check($sformatf("t2_data_%0d", i), ARspData, exp_a[i-1] ? 16'h1234 : 16'h5678);
         end
         cyc();
      end
      idle();
      #2;
      check("t2_last_rspA", ARspValA, 1);
      check("t2_last_data", ARspData, 16'h1234);
      cyc();

      // A alone for six cycles saturates its burst, B then wins at once
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 8'h30, 16'h0000, 0, 0, 8'h00, 16'h0000);
         #2;
         check($sformatf("t3_rdyA_%0d", i), ARdyA, 1);
         cyc();
      end
      drive(1, 0, 8'h30, 16'h0000, 1, 0, 8'h20, 16'h0000);
      #2;
      check("t3_join_rdyB", ARdyB, 1);
      check("t3_join_rdyA", ARdyA, 0);
      check("t3_rspA", ARspValA, 1);
      check("t3_dataA", ARspData, 16'h9ABC);
      cyc();
      idle();
      #2;
      check("t3_rspB", ARspValB, 1);
      check("t3_dataB", ARspData, 16'h5678);
      cyc();

      // B writes, A reads the same address on the next cycle
      drive(0, 0, 8'h00, 16'h0000, 1, 1, 8'h03, 16'hBEEF);
      #2;
      check("t4_rdyB", ARdyB, 1);
      check("t4_wren", ARamWrEn, 1);
      check("t4_mosi", ARamMosi, 16'hBEEF);
      cyc();
      drive(1, 0, 8'h03, 16'h0000, 0, 0, 8'h00, 16'h0000);
      #2;
      check("t4_rdyA", ARdyA, 1);
      cyc();
      idle();
      #2;
      check("t4_rspA", ARspValA, 1);
      check("t4_data", ARspData, 16'hBEEF);
      cyc();

      // clock enable low holds the response and blocks grants
      drive(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
      cyc();
      AClkHEn = 1'b0;
      drive(1, 0, 8'h30, 16'h0000, 1, 1, 8'h40, 16'h7777);
      for (int i = 0; i < 3; i++) begin
         #2;
         check($sformatf("t5_rdyA_%0d", i), ARdyA, 0);
         check($sformatf("t5_rdyB_%0d", i), ARdyB, 0);
         check($sformatf("t5_wren_%0d", i), ARamWrEn, 0);
         check($sformatf("t5_rspA_%0d", i), ARspValA, 1);
         check($sformatf("t5_data_%0d", i), ARspData, 16'h1234);
         cyc();
      end
      AClkHEn = 1'b1;
      #2;
      check("t5_resume_rdyA", ARdyA, 1);
      check("t5_resume_rdyB", ARdyB, 0);
      cyc();
      idle();
      #2;
      check("t5_resume_rspA", ARspValA, 1);
      check("t5_resume_data", ARspData, 16'h9ABC);
      cyc();

      // reset while B owns the burst with a read response in flight
      drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000);
      #2;
      check("t6_rdyB", ARdyB, 1);
      cyc();
      #2;
      check("t6_rspB_pre", ARspValB, 1);
      AResetB = 1'b0;
      #1;
      check("t6_rspB_rst", ARspValB, 0);
      #1;
      AResetB = 1'b1;
      drive(1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
      #1;
      check("t6_both_rdyA", ARdyA, 1);
      check("t6_both_rdyB", ARdyB, 0);
      cyc();
      idle();
      #2;
      check("t6_rspA", ARspValA, 1);
      check("t6_rspB", ARspValB, 0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
